// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and the default board line rate.
package uart_pkg;

    localparam int UART_CLK_HZ = 100_000_000;
    localparam int UART_BAUD   = 115_200;

    // Nearest whole number of clocks per bit for a given clock and baud rate.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

    localparam int UART_CLKS_PER_BIT = clks_per_bit(UART_CLK_HZ, UART_BAUD);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_REQ   = 3'd1,
        TX_WAIT  = 3'd2,
        TX_START = 3'd3,
        TX_DATA  = 3'd4,
        TX_STOP  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte request/response link between the output value generator and the UART transmitter.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  tx_ready;

    modport master (
        output in_data,
        output in_valid,
        input  tx_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts enabled cycles and flags the last cycle of each bit period.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Gated by en so a frozen counter sitting on its last count does not retrigger.
    assign bit_done = en && (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == CNT_LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter: polls the generator for one byte at a time and shifts
// it out LSB first between a start and a stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    uart_tx_serializer_if.slave gen,
    output logic                tx,
    output logic                busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = TX_IDLE;
    localparam logic [2:0] S_REQ   = TX_REQ;
    localparam logic [2:0] S_WAIT  = TX_WAIT;
    localparam logic [2:0] S_START = TX_START;
    localparam logic [2:0] S_DATA  = TX_DATA;
    localparam logic [2:0] S_STOP  = TX_STOP;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [BIT_W-1:0]      bit_idx_q;
    logic [BIT_W-1:0]      bit_idx_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  tx_ready_q;
    logic                  tx_ready_d;
    logic                  busy_q;
    logic                  busy_d;

    logic in_frame;
    logic baud_en;
    logic baud_clear;
    logic bit_done;

    assign in_frame = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign baud_en  = ena && in_frame;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .en      (baud_en),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_clear = 1'b0;
        if (ena) begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    // No valid byte: fall back to IDLE so the request repeats every 3 cycles.
                    if (gen.in_valid) begin
                        shift_d    = gen.in_data;
                        bit_idx_d  = '0;
                        baud_clear = 1'b1;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they track it with no input-to-output path.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d     = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
        tx_ready_d = (state_q == S_IDLE) && (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign gen.tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer at 4 clocks per bit: generator model feeds bytes,
// a UART decoder checks every frame against the queue of bytes handed over.
module tb_uart_tx_serializer;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic clk;
    logic reset;
    logic ena;
    logic tx;
    logic busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) gen_if ();

    uart_tx_serializer #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ena  (ena),
        .gen  (gen_if),
        .tx   (tx),
        .busy (busy)
    );

    logic [7:0] gen_q[$];
    logic [7:0] exp_q[$];
    bit         gen_valid    = 1'b1;
    bit         gap_check    = 1'b0;
    bit         mon_in_frame = 1'b0;
    int         last_end     = -1;
    int         frames_done  = 0;
    int         aborted      = 0;

    int   low_runs[$];
    int   low_cnt         = 0;
    int   busy_cnt        = 0;
    int   last_busy       = 0;
    int   viol_consec     = 0;
    int   viol_ready_busy = 0;
    logic prev_ready      = 1'b0;

    logic [7:0] str_bytes [10] = '{8'h4C, 8'h44, 8'h3A, 8'h20, 8'h30,
                                   8'h78, 8'h31, 8'h32, 8'h33, 8'h34};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish within 10000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int run_at(input int i);
        if (i < low_runs.size()) return low_runs[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(gen_q.size() == 0 && exp_q.size() == 0 &&
                               !mon_in_frame && busy === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_done_in_budget"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    // Generator model: answers each request with the next queued byte in the WAIT cycle.
    initial begin : generator
        gen_if.in_valid = 1'b0;
        gen_if.in_data  = '0;
        forever begin
            @(negedge clk);
            if (gen_if.tx_ready === 1'b1) begin
                tick();
                if (gen_valid && gen_q.size() > 0) begin
                    gen_if.in_data  = gen_q.pop_front();
                    gen_if.in_valid = 1'b1;
                    exp_q.push_back(gen_if.in_data);
                end else begin
                    gen_if.in_data  = 8'hFF;
                    gen_if.in_valid = 1'b0;
                end
                tick();
                gen_if.in_valid = 1'b0;
            end
        end
    end

    // Line probe: low-run lengths, busy-run lengths and handshake invariants.
    initial begin : probe
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                low_runs.push_back(low_cnt);
                low_cnt = 0;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
            end else if (busy_cnt > 0) begin
                last_busy = busy_cnt;
                busy_cnt  = 0;
            end
            if (gen_if.tx_ready === 1'b1 && prev_ready === 1'b1) viol_consec++;
            if (gen_if.tx_ready === 1'b1 && busy === 1'b1) viol_ready_busy++;
            prev_ready = gen_if.tx_ready;
        end
    end

    // UART decoder: counts only enabled cycles, samples each bit in its third cycle.
    initial begin : monitor
        int         act;
        int         start_cyc;
        logic [9:0] bits;
        act       = 0;
        start_cyc = 0;
        bits      = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (mon_in_frame) begin
                    mon_in_frame = 1'b0;
                    aborted++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else begin
                if (!mon_in_frame && tx === 1'b0 && ena === 1'b1) begin
                    mon_in_frame = 1'b1;
                    act          = 0;
                    start_cyc    = cyc;
                    if (gap_check && last_end >= 0)
                        check("frame_gap", start_cyc - last_end - 1, 3);
                end
                if (mon_in_frame && ena === 1'b1) begin
                    if (act % CPB == 2) bits[act / CPB] = tx;
                    act++;
                    if (act == FRAME) begin
                        mon_in_frame = 1'b0;
                        last_end     = cyc;
                        frames_done++;
                        check("frame_start_bit", int'(bits[0]), 0);
                        check("frame_stop_bit", int'(bits[9]), 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: got 0x%0h required no frame", bits[8:1]);
                        end else begin
                            check("frame_byte", int'(bits[8:1]), int'(exp_q.pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int         t0;
        int         rel;
        int         first_ready;
        int         first_low;
        int         busy_n;
        int         frames0;
        int         pulses;
        int         prev_p;
        int         bad_int;
        int         tx_low;
        int         busy_hi;
        logic [9:0] bits;
        bit         found;

        reset = 1'b1;
        ena   = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_tx_ready", int'(gen_if.tx_ready), 0);
        check("reset_busy", int'(busy), 0);

        // Single 'L' frame, cycle 0 is the first enabled IDLE cycle.
        gen_q.push_back(8'h4C);
        low_runs.delete();
        tick();
        reset = 1'b0;
        ena   = 1'b1;
        t0    = cyc;
        first_ready = -1;
        first_low   = -1;
        busy_n      = 0;
        bits        = '0;
        for (int k = 0; k <= 42; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (gen_if.tx_ready === 1'b1 && first_ready < 0) first_ready = rel;
            if (tx === 1'b0 && first_low < 0) first_low = rel;
            if (busy === 1'b1) busy_n++;
            for (int b = 0; b < 10; b++) begin
                if (rel == 3 + 4 * b + 2) bits[b] = tx;
            end
        end
        check("L_ready_cycle", first_ready, 1);
        check("L_start_cycle", first_low, 3);
        check("L_busy_cycles", busy_n, 40);
        check("L_bit_samples", int'(bits), 10'h298);
        wait_idle("L", 200);
        check("L_low_run_count", low_runs.size(), 3);
        check("L_low_run0", run_at(0), 12);
        check("L_low_run1", run_at(1), 8);
        check("L_low_run2", run_at(2), 4);
        check("L_busy_len", last_busy, 40);

        // "LD: 0x1234" back to back.
        last_end  = -1;
        gap_check = 1'b1;
        frames0   = frames_done;
        for (int i = 0; i < 10; i++) gen_q.push_back(str_bytes[i]);
        wait_idle("string", 700);
        gap_check = 1'b0;
        check("string_frames", frames_done - frames0, 10);

        // Polling with no valid data.
        gen_valid = 1'b0;
        pulses  = 0;
        prev_p  = -1;
        bad_int = 0;
        tx_low  = 0;
        busy_hi = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gen_if.tx_ready === 1'b1) begin
                pulses++;
                if (prev_p >= 0 && (k - prev_p) != 3) bad_int++;
                prev_p = k;
            end
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_hi++;
        end
        check("poll_pulses", pulses, 10);
        check("poll_bad_intervals", bad_int, 0);
        check("poll_tx_low_cycles", tx_low, 0);
        check("poll_busy_cycles", busy_hi, 0);
        gen_valid = 1'b1;

        // 0xA5 with ena low for 7 cycles inside data bit 3.
        low_runs.delete();
        gen_q.push_back(8'hA5);
        wait_start(found);
        check("A5_start_seen", int'(found), 1);
        if (found) begin
            repeat (17) tick();
            ena = 1'b0;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                check("stall_tx_hold", int'(tx), 0);
                check("stall_no_ready", int'(gen_if.tx_ready), 0);
                tick();
            end
            ena = 1'b1;
        end
        wait_idle("A5", 200);
        check("A5_low_run_count", low_runs.size(), 4);
        check("A5_low_run0", run_at(0), 4);
        check("A5_low_run1", run_at(1), 4);
        check("A5_stretched_run", run_at(2), 15);
        check("A5_low_run3", run_at(3), 4);
        check("A5_busy_len", last_busy, 47);

        // 0x1F aborted by a one-cycle reset in data bit 5, then a NUL byte.
        gen_q.push_back(8'h1F);
        wait_start(found);
        check("abort_start_seen", int'(found), 1);
        if (found) begin
            repeat (25) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            gen_q.push_back(8'h00);
            @(negedge clk);
            check("abort_tx", int'(tx), 1);
            check("abort_busy", int'(busy), 0);
            check("abort_tx_ready", int'(gen_if.tx_ready), 0);
            @(negedge clk);
            check("abort_req_after_release", int'(gen_if.tx_ready), 1);
            low_runs.delete();
        end
        wait_idle("nul", 200);
        check("nul_low_run_count", low_runs.size(), 1);
        check("nul_low_run", run_at(0), 36);
        check("nul_busy_len", last_busy, 40);

        check("frames_total", frames_done, 13);
        check("frames_aborted", aborted, 1);
        check("ready_consecutive", viol_consec, 0);
        check("ready_while_busy", viol_ready_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmit stage downstream of the output value generator: pulls one ASCII byte at a time over a request/response handshake and shifts it out on the Basys3 UART TX pin as 8N1 (start bit, 8 data bits LSB first, stop bit). Generates the one-cycle `tx_ready` request pulse the generator uses to advance its character buffer. One byte in flight; no FIFO.

## Interface
- `DATA_WIDTH`, 8, bits per frame payload.
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- `clk` input 1, system clock.
- `reset` input 1, reset, synchronous and active-high.
- `ena` input 1, global enable; low freezes all state, counters and outputs.
- `in_data` input DATA_WIDTH, byte from the generator, valid in the cycle after a `tx_ready` pulse.
- `in_valid` input 1, qualifies `in_data` in that cycle.
- `tx_ready` output 1, one-cycle request pulse for the next byte.
- `tx` output 1, serial line, idle high.
- `busy` output 1, high from START entry through the last STOP cycle.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE: `tx`=1. If `ena`, go to REQ next cycle.
- REQ: `tx_ready`=1 for exactly this cycle; go to WAIT.
- WAIT: sample `in_valid`. If 1: capture `in_data` into the shift register, clear bit and baud counters, go to START. If 0: go to IDLE; the request repeats, giving a 3-cycle polling loop.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `tx` = shift_reg[0]; after CLKS_PER_BIT cycles, shift right, increment bit index; after bit DATA_WIDTH-1, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- Every payload with `in_valid`=1 is sent, including 0x00. No filtering.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps to 0 on a bit boundary. Bit index: $clog2(DATA_WIDTH) bits.
- `in_valid`/`in_data` are ignored outside WAIT.
- `ena` low in any state holds state, counters, shift register and `tx` level. A REQ cycle with `ena` low does not emit `tx_ready`, and the pulse is not repeated on resume. Operation resumes unchanged when `ena` rises.
- `reset` mid-frame aborts the frame. The line returns high on the next cycle, and the truncated frame is not retried.

## Timing
- Reset values: `tx`=1, `tx_ready`=0, `busy`=0, state IDLE, counters 0, shift register 0.
- All outputs are registered-state decodes, with no combinational path from inputs.
- With `ena` held high:
  - `tx_ready` is asserted 1 cycle after leaving IDLE.
  - Data is sampled in the following cycle.
  - The `tx` falling edge (start bit) occurs on the cycle after the WAIT sample.
- Frame length is (DATA_WIDTH+2)·CLKS_PER_BIT cycles.
- Inter-frame gap is 3 cycles of high line (IDLE, REQ, WAIT), so back-to-back throughput is one byte per 10·CLKS_PER_BIT+3 cycles.
- `tx_ready` is never high on two consecutive cycles.
- `tx_ready` is never high while `busy`.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, REQ, WAIT, START, DATA, STOP).
  - Default constants `UART_CLK_HZ`=100_000_000, `UART_BAUD`=115200.
  - Derived `UART_CLKS_PER_BIT`.
- Sub-module `uart_baud_counter`: enable-gated, clearable counter with a one-cycle `bit_done` output at count CLKS_PER_BIT-1. It is reused by the future RX stage.

## Test plan
Bench uses CLKS_PER_BIT=4.
- Reset, then `ena`=1 with a generator model returning 0x4C ('L') valid:
  - `tx_ready` pulses at cycle 1.
  - Start bit begins at cycle 3.
  - `tx` bits read 0,0,0,1,1,0,0,1,0 then 1, each 4 cycles wide.
  - `busy` is high for 40 cycles.
- Full "LD: 0x1234" string from a generator model: 10 frames decoded by the bench's UART monitor match the ASCII bytes in order; measured gaps are exactly 3 cycles.
- `in_valid`=0 on every request:
  - `tx_ready` pulses every 3 cycles.
  - `tx` stays 1.
  - `busy` stays 0.
- `ena` dropped for 7 cycles in the middle of data bit 3 of 0xA5: `tx` holds its level and the decoded byte is still 0xA5. The stretched bit lasts 4+7 cycles.
- `reset` asserted for 1 cycle during data bit 5:
  - Next cycle: `tx`=1, `busy`=0, `tx_ready`=0.
  - After release, a new request pulse occurs 1 cycle later.
- Payload 0x00 with `in_valid`=1: a full frame is sent (start, 8 zeros, stop), demonstrating that NUL bytes are not filtered.
